// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Each cycle the execute-stage state takes exactly one action, by priority:
// reset > FlushE > HoldE > load-use bubble > capture of the decode slot.
// StallF/StallD are combinational and freeze fetch and IF/ID while execute
// is held or while a load-use bubble is being inserted.
// Optional build macro: IDEX_PERF_CNT_EN adds a saturating 32-bit BubbleCnt
// output that counts bubbles inserted by FlushE or by load-use.
module id_ex_register #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      ResultSrcD,
   input  logic            BranchD,
   input  logic            MemWriteD,
   input  logic            ALUSrcD,
   input  logic            RegWriteD,
   input  logic [2:0]      ALUControlD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic            ValidD,
   input  logic            FlushE,
   input  logic            HoldE,
   output logic [1:0]      ResultSrcE,
   output logic            BranchE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic            RegWriteE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            ValidE,
   output logic            StallF,
   output logic            StallD
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]     BubbleCnt
`endif
);

   // Execute-stage state; an all-zero value is the bubble.
   typedef struct packed {
      logic            valid;
      logic [1:0]      result_src;
      logic            branch;
      logic            mem_write;
      logic            alu_src;
      logic            reg_write;
      logic [2:0]      alu_control;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } ex_t;

   ex_t  r_ex;
   ex_t  w_d;
   ex_t  w_ex_next;
   logic w_load_use;
   logic w_bubble_load;
   logic w_stall;

   // Pack the decode-stage slot into the execute-state layout.
   always_comb begin
      w_d             = '0;
      w_d.valid       = ValidD;
      w_d.result_src  = ResultSrcD;
      w_d.branch      = BranchD;
      w_d.mem_write   = MemWriteD;
      w_d.alu_src     = ALUSrcD;
      w_d.reg_write   = RegWriteD;
      w_d.alu_control = ALUControlD;
      w_d.rd1         = RD1D;
      w_d.rd2         = RD2D;
      w_d.imm_ext     = ImmExtD;
      w_d.pc          = PCD;
      w_d.pc_plus4    = PCPlus4D;
      w_d.rs1         = Rs1D;
      w_d.rs2         = Rs2D;
      w_d.rd          = RdD;
   end

   // A load in execute whose destination is read by a valid decode slot.
   // Both source indices are compared even if the instruction ignores one.
   always_comb begin
      w_load_use = r_ex.valid && r_ex.reg_write && (r_ex.result_src == 2'b01) &&
                   (r_ex.rd != 5'd0) && ((r_ex.rd == Rs1D) || (r_ex.rd == Rs2D)) &&
                   ValidD;
   end

   // Bubble sources that count as inserted bubbles; stalls for fetch/decode.
   always_comb begin
      w_bubble_load = FlushE || (!HoldE && w_load_use);
      w_stall       = rst_n && !FlushE && (HoldE || w_load_use);
   end

   // Next execute state by priority: flush, hold, load-use bubble, capture.
   always_comb begin
      w_ex_next = r_ex;
      if (FlushE)          w_ex_next = '0;
      else if (HoldE)      w_ex_next = r_ex;
      else if (w_load_use) w_ex_next = '0;
      else                 w_ex_next = w_d;
   end

   // Execute-stage register; synchronous reset loads the bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) r_ex <= '0;
      else        r_ex <= w_ex_next;
   end

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] r_bubble_cnt;

   // Saturating count of bubbles inserted by flush or load-use.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_bubble_cnt <= '0;
      else if (w_bubble_load && (r_bubble_cnt != 32'hFFFF_FFFF))
         r_bubble_cnt <= r_bubble_cnt + 32'd1;
   end

   assign BubbleCnt = r_bubble_cnt;
`else
   logic w_unused_bubble;
   assign w_unused_bubble = w_bubble_load;
`endif

   assign ValidE      = r_ex.valid;
   assign ResultSrcE  = r_ex.result_src;
   assign BranchE     = r_ex.branch;
   assign MemWriteE   = r_ex.mem_write;
   assign ALUSrcE     = r_ex.alu_src;
   assign RegWriteE   = r_ex.reg_write;
   assign ALUControlE = r_ex.alu_control;
   assign RD1E        = r_ex.rd1;
   assign RD2E        = r_ex.rd2;
   assign ImmExtE     = r_ex.imm_ext;
   assign PCE         = r_ex.pc;
   assign PCPlus4E    = r_ex.pc_plus4;
   assign Rs1E        = r_ex.rs1;
   assign Rs2E        = r_ex.rs2;
   assign RdE         = r_ex.rd;
   assign StallF      = w_stall;
   assign StallD      = w_stall;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: scenario tasks drive the decode slot, a spec-level
// model pushes the expected execute state to a queue, and each task pops and
// compares it after the clock edge. Counter checks exist when
// IDEX_PERF_CNT_EN is defined.
module tb_id_ex_register;
   localparam int XLEN = 32;
   localparam int EW   = 185;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      ResultSrcD;
   logic            BranchD, MemWriteD, ALUSrcD, RegWriteD;
   logic [2:0]      ALUControlD;
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [4:0]      Rs1D, Rs2D, RdD;
   logic            ValidD, FlushE, HoldE;
   logic [1:0]      ResultSrcE;
   logic            BranchE, MemWriteE, ALUSrcE, RegWriteE;
   logic [2:0]      ALUControlE;
   logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]      Rs1E, Rs2E, RdE;
   logic            ValidE, StallF, StallD;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0]     BubbleCnt;
`endif

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] m_e;
   logic [31:0]   m_cnt;
   int            n_err = 0;
   int            n_chk = 0;

   // clock / reset
   always #5 clk = ~clk;

   id_ex_register #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .ResultSrcD(ResultSrcD), .BranchD(BranchD), .MemWriteD(MemWriteD),
      .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ALUControlD(ALUControlD),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
      .FlushE(FlushE), .HoldE(HoldE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
      .StallF(StallF), .StallD(StallD)
`ifdef IDEX_PERF_CNT_EN
      , .BubbleCnt(BubbleCnt)
`endif
   );

   logic [EW-1:0] dut_e;
   assign dut_e = {ValidE, ResultSrcE, BranchE, MemWriteE, ALUSrcE, RegWriteE, ALUControlE,
                   RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

   // Decode slot as seen by the bench, in execute-state layout.
   function automatic logic [EW-1:0] d_vec();
      return {ValidD, ResultSrcD, BranchD, MemWriteD, ALUSrcD, RegWriteD, ALUControlD,
              RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};
   endfunction

   // Load-use condition from the model's execute state and the decode slot.
   function automatic logic model_lu();
      return m_e[184] && m_e[178] && (m_e[183:182] == 2'b01) && (m_e[4:0] != 5'd0) &&
             ((m_e[4:0] == Rs1D) || (m_e[4:0] == Rs2D)) && ValidD;
   endfunction

   function automatic logic model_stall();
      return rst_n && !FlushE && (HoldE || model_lu());
   endfunction

   // driver: set the decode slot; data fields not named are randomized
   task automatic set_d(input logic v, input logic [1:0] rs, input logic rw,
                        input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] alu, input logic [31:0] d1);
      ValidD = v; ResultSrcD = rs; RegWriteD = rw; RdD = rd; Rs1D = s1; Rs2D = s2;
      ALUControlD = alu; RD1D = d1;
      MemWriteD = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
      ALUSrcD = 1'($urandom_range(0, 1));
      RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom; PCPlus4D = PCD + 32'd4;
   endtask

   // driver: push the expected next state, advance the model, clock once
   task automatic tick();
      logic [EW-1:0] nxt;
      logic          lu;
      lu = model_lu();
      if (!rst_n)      nxt = '0;
      else if (FlushE) nxt = '0;
      else if (HoldE)  nxt = m_e;
      else if (lu)     nxt = '0;
      else             nxt = d_vec();
      if (!rst_n) m_cnt = 0;
      else if ((FlushE || (!HoldE && lu)) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      exp_q.push_back(nxt);
      m_e = nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [EW-1:0] exp;
      rst_n = 1'b0; FlushE = 1'b1; HoldE = 1'b1;
      set_d(1'b1, 2'b01, 1'b1, 5'd9, 5'd3, 5'd4, 3'b111, 32'hDEAD_BEEF);
      tick();
      tick();
      n_chk++;
      if (StallF !== 1'b0 || StallD !== 1'b0) begin
         n_err++; $display("FAIL reset_stall: got %b%b exp 00", StallF, StallD);
      end
      exp = exp_q.pop_front(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || dut_e !== '0) begin
         n_err++; $display("FAIL reset_state: got %h exp %h", dut_e, exp);
      end
`ifdef IDEX_PERF_CNT_EN
      n_chk++;
      if (BubbleCnt !== 32'd0) begin
         n_err++; $display("FAIL reset_cnt: got %0d exp 0", BubbleCnt);
      end
`endif
      rst_n = 1'b1; FlushE = 1'b0; HoldE = 1'b0;
   endtask

   task automatic test_capture();
      logic [EW-1:0] exp;
      set_d(1'b1, 2'b00, 1'b1, 5'd5, 5'd1, 5'd2, 3'b010, 32'h0000_1234);
      #1;
      n_chk++;
      if (StallD !== model_stall() || StallD !== 1'b0) begin
         n_err++; $display("FAIL capture_stall: got %b exp 0", StallD);
      end
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp) begin
         n_err++; $display("FAIL capture_state: got %h exp %h", dut_e, exp);
      end
      n_chk++;
      if (RdE !== 5'd5 || ALUControlE !== 3'b010 || RD1E !== 32'h1234 || ValidE !== 1'b1) begin
         n_err++; $display("FAIL capture_fields: got rd=%0d alu=%b rd1=%h v=%b exp 5 010 1234 1",
                           RdE, ALUControlE, RD1E, ValidE);
      end
   endtask

   task automatic test_load_use();
      logic [EW-1:0] exp;
      logic [31:0]   cnt0;
      set_d(1'b1, 2'b01, 1'b1, 5'd5, 5'd1, 5'd2, 3'b000, 32'h0);   // lw x5
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp) begin
         n_err++; $display("FAIL lu_load: got %h exp %h", dut_e, exp);
      end
      cnt0 = m_cnt;
      set_d(1'b1, 2'b00, 1'b1, 5'd6, 5'd5, 5'd7, 3'b000, 32'h55);  // add x6,x5,x7
      #1;
      n_chk++;
      if (StallF !== 1'b1 || StallD !== 1'b1 || model_stall() !== 1'b1) begin
         n_err++; $display("FAIL lu_stall: got %b%b exp 11", StallF, StallD);
      end
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || ValidE !== 1'b0) begin
         n_err++; $display("FAIL lu_bubble: got %h exp %h", dut_e, exp);
      end
      n_chk++;
      if (StallF !== 1'b0 || StallD !== 1'b0) begin
         n_err++; $display("FAIL lu_release: got %b%b exp 00", StallF, StallD);
      end
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || RdE !== 5'd6 || ValidE !== 1'b1) begin
         n_err++; $display("FAIL lu_capture: got %h exp %h", dut_e, exp);
      end
`ifdef IDEX_PERF_CNT_EN
      n_chk++;
      if (BubbleCnt !== m_cnt || BubbleCnt !== cnt0 + 32'd1) begin
         n_err++; $display("FAIL lu_cnt: got %0d exp %0d", BubbleCnt, cnt0 + 1);
      end
`endif
   endtask

   task automatic test_no_stall_cases();
      logic [EW-1:0] exp;
      // lw x0 then a reader of x0; then lw x7 followed by an invalid slot reading x7
      for (int k = 0; k < 2; k++) begin
         set_d(1'b1, 2'b01, 1'b1, (k == 0) ? 5'd0 : 5'd7, 5'd3, 5'd4, 3'b000, 32'h0);
         tick(); exp = exp_q.pop_front();
         n_chk++;
         if (dut_e !== exp) begin
            n_err++; $display("FAIL nostall_load%0d: got %h exp %h", k, dut_e, exp);
         end
         set_d((k == 0), 2'b00, 1'b1, 5'd8, (k == 0) ? 5'd0 : 5'd7, 5'd0, 3'b011, $urandom);
         #1;
         n_chk++;
         if (StallD !== 1'b0 || StallF !== 1'b0) begin
            n_err++; $display("FAIL nostall_stall%0d: got %b%b exp 00", k, StallF, StallD);
         end
         tick(); exp = exp_q.pop_front();
         n_chk++;
         if (dut_e !== exp || RdE !== 5'd8 || ValidE !== (k == 0)) begin
            n_err++; $display("FAIL nostall_capture%0d: got %h exp %h", k, dut_e, exp);
         end
      end
   endtask

   task automatic test_flush_hold();
      logic [EW-1:0] exp;
      logic [31:0]   cnt0;
      set_d(1'b1, 2'b01, 1'b1, 5'd5, 5'd1, 5'd2, 3'b000, 32'h0);
      tick(); exp = exp_q.pop_front();
      cnt0 = m_cnt;
      set_d(1'b1, 2'b00, 1'b1, 5'd6, 5'd5, 5'd5, 3'b001, 32'h77);
      FlushE = 1'b1; HoldE = 1'b1;
      #1;
      n_chk++;
      if (StallD !== 1'b0 || StallF !== 1'b0) begin
         n_err++; $display("FAIL flush_stall: got %b%b exp 00", StallF, StallD);
      end
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || dut_e !== '0) begin
         n_err++; $display("FAIL flush_bubble: got %h exp %h", dut_e, exp);
      end
`ifdef IDEX_PERF_CNT_EN
      n_chk++;
      if (BubbleCnt !== cnt0 + 32'd1) begin
         n_err++; $display("FAIL flush_cnt: got %0d exp %0d", BubbleCnt, cnt0 + 1);
      end
`endif
      FlushE = 1'b0; HoldE = 1'b0;
   endtask

   task automatic test_hold();
      logic [EW-1:0] exp, held;
      logic [31:0]   cnt0;
      set_d(1'b1, 2'b00, 1'b1, 5'd12, 5'd10, 5'd11, 3'b110, 32'hCAFE_0001);
      tick(); exp = exp_q.pop_front(); held = dut_e;
      cnt0 = m_cnt;
      HoldE = 1'b1;
      for (int c = 0; c < 3; c++) begin
         set_d(1'b1, 2'b01, 1'b1, 5'($urandom_range(1, 31)), 5'd12, 5'd12, 3'($urandom), $urandom);
         #1;
         n_chk++;
         if (StallF !== 1'b1 || StallD !== 1'b1) begin
            n_err++; $display("FAIL hold_stall%0d: got %b%b exp 11", c, StallF, StallD);
         end
         tick(); exp = exp_q.pop_front();
         n_chk++;
         if (dut_e !== exp || dut_e !== held) begin
            n_err++; $display("FAIL hold_state%0d: got %h exp %h", c, dut_e, held);
         end
      end
`ifdef IDEX_PERF_CNT_EN
      n_chk++;
      if (BubbleCnt !== cnt0) begin
         n_err++; $display("FAIL hold_cnt: got %0d exp %0d", BubbleCnt, cnt0);
      end
`endif
      HoldE = 1'b0;
      set_d(1'b1, 2'b00, 1'b0, 5'd13, 5'd1, 5'd2, 3'b100, 32'h4444);
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || RdE !== 5'd13) begin
         n_err++; $display("FAIL hold_release: got %h exp %h", dut_e, exp);
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [EW-1:0] exp;
      HoldE = 1'b1;
      tick(); exp = exp_q.pop_front();
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (StallF !== 1'b0 || StallD !== 1'b0) begin
         n_err++; $display("FAIL rsthold_stall: got %b%b exp 00", StallF, StallD);
      end
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || dut_e !== '0) begin
         n_err++; $display("FAIL rsthold_state: got %h exp 0", dut_e);
      end
`ifdef IDEX_PERF_CNT_EN
      n_chk++;
      if (BubbleCnt !== 32'd0) begin
         n_err++; $display("FAIL rsthold_cnt: got %0d exp 0", BubbleCnt);
      end
`endif
      rst_n = 1'b1; HoldE = 1'b0;
      set_d(1'b1, 2'b00, 1'b1, 5'd3, 5'd1, 5'd2, 3'b101, 32'h9);
      tick(); exp = exp_q.pop_front();
      n_chk++;
      if (dut_e !== exp || RdE !== 5'd3) begin
         n_err++; $display("FAIL rsthold_first: got %h exp %h", dut_e, exp);
      end
   endtask

   task automatic test_random();
      logic [EW-1:0] exp;
      for (int c = 0; c < 400; c++) begin
         rst_n  = ($urandom_range(0, 39) != 0);
         FlushE = ($urandom_range(0, 9) == 0);
         HoldE  = ($urandom_range(0, 5) == 0);
         set_d(($urandom_range(0, 4) != 0), 2'($urandom), 1'($urandom),
               5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
               3'($urandom), $urandom);
         #1;
         n_chk++;
         if (StallF !== model_stall() || StallD !== model_stall()) begin
            n_err++; $display("FAIL rand_stall%0d: got %b%b exp %b", c, StallF, StallD, model_stall());
         end
         tick(); exp = exp_q.pop_front();
         n_chk++;
         if (dut_e !== exp) begin
            n_err++; $display("FAIL rand_state%0d: got %h exp %h", c, dut_e, exp);
         end
`ifdef IDEX_PERF_CNT_EN
         n_chk++;
         if (BubbleCnt !== m_cnt) begin
            n_err++; $display("FAIL rand_cnt%0d: got %0d exp %0d", c, BubbleCnt, m_cnt);
         end
`endif
      end
      rst_n = 1'b1; FlushE = 1'b0; HoldE = 1'b0;
   endtask

   initial begin
      m_e = '0; m_cnt = 0;
      rst_n = 1'b0; FlushE = 1'b0; HoldE = 1'b0;
      set_d(1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0);
      test_reset();
      test_capture();
      test_load_use();
      test_no_stall_cases();
      test_flush_hold();
      test_hold();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
